// File: rtl/hls_tb_pkg.sv
// Shared types and constants for the HLS slave-port memory loader: FSM states,
// result status codes and the default slave-port field widths.
package hls_tb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_READ,
    S_START,
    S_RUN,
    S_REPORT
  } state_t;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_RUN_TO   = 2'd1;
  localparam logic [1:0] ST_MISMATCH = 2'd2;
  localparam logic [1:0] ST_SLAVE_TO = 2'd3;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_SIZE_W = 7;

endpackage

// File: rtl/hls_slave_access.sv
// Single-channel slave handshake: flags completion when DataRdy meets an active
// request, and flags a timeout after TIMEOUT request cycles without DataRdy.
module hls_slave_access #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              data_rdy,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              done,
  output logic              timeout,
  output logic [DATA_W-1:0] rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign done    = req && data_rdy;
  assign timeout = req && !data_rdy && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign rdata   = rdata_in;

  // The counter restarts on every completion so back-to-back accesses
  // (write then verify read) each get a full timeout window.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset || !req || data_rdy) wait_cnt <= '0;
    else if (!timeout)              wait_cnt <= wait_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/hls_slave_mem_loader.sv
// Packs a little-endian byte stream into words, loads them through slave
// channel 0 (optionally verifying each), then starts the HLS core and times it.
module hls_slave_mem_loader
  import hls_tb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int SIZE_W        = DEF_SIZE_W,
  parameter int WORD_BYTES    = 4,
  parameter int VERIFY        = 1,
  parameter int SLAVE_TIMEOUT = 1024,
  parameter int MAX_CYCLES    = 200000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         cfg_base_addr,
  input  logic                cfg_valid,
  input  logic [7:0]          byte_data,
  input  logic                byte_valid,
  input  logic                byte_last,
  output logic                byte_ready,
  output logic [1:0]          S_oe_ram,
  output logic [1:0]          S_we_ram,
  output logic [2*ADDR_W-1:0] S_addr_ram,
  output logic [2*DATA_W-1:0] S_Wdata_ram,
  output logic [2*SIZE_W-1:0] S_data_ram_size,
  input  logic [2*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [1:0]          Sout_DataRdy,
  output logic                start_port,
  input  logic                done_port,
  output logic                res_valid,
  output logic [31:0]         res_cycles,
  output logic [1:0]          res_status
);

  localparam int WB_W  = 8 * WORD_BYTES;
  localparam int CNT_W = $clog2(WORD_BYTES + 1);

  state_t             state;
  logic [31:0]        base, offset, run_cnt;
  logic [CNT_W-1:0]   count, count_inc;
  logic [WB_W-1:0]    word_buf, word_next, lane_mask;
  logic               last_seen;
  logic               we0, oe0;
  logic [ADDR_W-1:0]  addr0;
  logic [DATA_W-1:0]  wdata0;
  logic [SIZE_W-1:0]  size0;
  logic               acc_active, acc_done, acc_timeout, mismatch, retire, abort;
  logic [DATA_W-1:0]  acc_rdata;
  logic               byte_fire, word_full;
  logic [31:0]        byte_addr;
  logic               unused_bits;

  assign byte_fire  = byte_valid && byte_ready;
  assign word_full  = byte_last || (count == CNT_W'(WORD_BYTES - 1));
  assign count_inc  = count + CNT_W'(1);
  assign byte_addr  = base + offset;
  assign acc_active = (state == S_WRITE) || (state == S_READ);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    word_next = word_buf;
    lane_mask = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (CNT_W'(i) == count) word_next[8*i +: 8] = byte_data;
      if (CNT_W'(i) <  count) lane_mask[8*i +: 8] = 8'hFF;
    end
  end

  // Only the lanes actually written are compared; the slave may return
  // anything above them.
  assign mismatch = (state == S_READ) && ((acc_rdata[WB_W-1:0] & lane_mask) != word_buf);
  assign retire   = acc_active && acc_done && !((state == S_WRITE) && (VERIFY != 0)) && !mismatch;
  assign abort    = acc_active && (acc_timeout || (acc_done && mismatch));

  hls_slave_access #(
    .DATA_W  (DATA_W),
    .TIMEOUT (SLAVE_TIMEOUT)
  ) u_access (
    .clock    (clock),
    .reset    (reset),
    .req      (acc_active),
    .data_rdy (Sout_DataRdy[0]),
    .rdata_in (Sout_Rdata_ram[DATA_W-1:0]),
    .done     (acc_done),
    .timeout  (acc_timeout),
    .rdata    (acc_rdata)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      base       <= '0;
      offset     <= '0;
      count      <= '0;
      word_buf   <= '0;
      last_seen  <= 1'b0;
      run_cnt    <= '0;
      we0        <= 1'b0;
      oe0        <= 1'b0;
      addr0      <= '0;
      wdata0     <= '0;
      size0      <= '0;
      byte_ready <= 1'b0;
      start_port <= 1'b0;
      res_valid  <= 1'b0;
      res_cycles <= '0;
      res_status <= ST_OK;
    end else begin
      case (state)
        S_IDLE: if (cfg_valid) begin
          base       <= cfg_base_addr;
          offset     <= '0;
          count      <= '0;
          word_buf   <= '0;
          last_seen  <= 1'b0;
          res_cycles <= '0;
          res_status <= ST_OK;
          byte_ready <= 1'b1;
          state      <= S_COLLECT;
        end
        S_COLLECT: if (byte_fire) begin
          word_buf <= word_next;
          count    <= count_inc;
          if (word_full) begin
            last_seen  <= byte_last;
            byte_ready <= 1'b0;
            we0        <= 1'b1;
            addr0      <= byte_addr[ADDR_W-1:0];
            wdata0     <= DATA_W'(word_next);
            size0      <= SIZE_W'({count_inc, 3'b000});
            state      <= S_WRITE;
          end
        end
        S_WRITE: if (acc_done && (VERIFY != 0)) begin
          we0   <= 1'b0;
          oe0   <= 1'b1;
          state <= S_READ;
        end
        S_READ: ;
        S_START: begin
          start_port <= 1'b0;
          run_cnt    <= 32'd1;
          state      <= S_RUN;
        end
        S_RUN: begin
          if (done_port) begin
            res_cycles <= run_cnt;
            res_status <= ST_OK;
            res_valid  <= 1'b1;
            state      <= S_REPORT;
          end else if (run_cnt == 32'(MAX_CYCLES)) begin
            res_cycles <= 32'(MAX_CYCLES);
            res_status <= ST_RUN_TO;
            res_valid  <= 1'b1;
            state      <= S_REPORT;
          end else begin
            run_cnt <= run_cnt + 32'd1;
          end
        end
        S_REPORT: begin
          res_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Word retirement and access failure are shared by WRITE and READ.
      if (retire) begin
        we0      <= 1'b0;
        oe0      <= 1'b0;
        addr0    <= '0;
        wdata0   <= '0;
        size0    <= '0;
        offset   <= offset + 32'(count);
        count    <= '0;
        word_buf <= '0;
        if (last_seen) begin
          start_port <= 1'b1;
          state      <= S_START;
        end else begin
          byte_ready <= 1'b1;
          state      <= S_COLLECT;
        end
      end
      if (abort) begin
        we0        <= 1'b0;
        oe0        <= 1'b0;
        addr0      <= '0;
        wdata0     <= '0;
        size0      <= '0;
        res_status <= acc_timeout ? ST_SLAVE_TO : ST_MISMATCH;
        res_valid  <= 1'b1;
        state      <= S_REPORT;
      end
    end
  end

  // Channel 1 is never used.
  assign S_we_ram        = {1'b0, we0};
  assign S_oe_ram        = {1'b0, oe0};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, addr0};
  assign S_Wdata_ram     = {{DATA_W{1'b0}}, wdata0};
  assign S_data_ram_size = {{SIZE_W{1'b0}}, size0};

  assign unused_bits = ^{Sout_DataRdy[1], Sout_Rdata_ram[2*DATA_W-1:DATA_W], acc_rdata, byte_addr};

endmodule
